uart_tx_fifo: RTL and testbench

//   8N1 UART transmitter with a small write FIFO and a run-time bit-period divisor.

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write FIFO.
// Bit period is div+1 clocks, latched per frame at the FIFO pop.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIV_W-1:0]         div,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [7:0]       r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [7:0]       r_shift;
  logic [DIV_W-1:0] r_baud;
  logic [DIV_W-1:0] r_div_q;
  logic [2:0]       r_bit_idx;
  logic             r_tx;

  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_pop;
  logic             w_bit_end;
  logic [7:0]       w_head;

  assign w_count   = r_wptr - r_rptr;
  assign w_full    = (w_count == LP_FULL);
  assign w_empty   = (w_count == '0);
  assign w_wr      = wr_valid && !w_full;
  assign w_bit_end = (r_baud == '0);
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  // Pop either from idle or exactly at the end of a stop bit.
  assign w_pop = !w_empty &&
    ((r_state == S_IDLE) ||
     ((r_state == S_STOP) && w_bit_end));

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_baud    <= '0;
      r_div_q   <= '0;
      r_bit_idx <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_baud  <= div;
            r_div_q <= div;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= r_div_q;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= r_div_q;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            // Back-to-back frames: no idle cycle when data is queued.
            if (w_pop) begin
              r_shift <= w_head;
              r_baud  <= div;
              r_div_q <= div;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_ready   = !w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a line receiver model
// checks every frame's timing, bits and byte order.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] div = 16'd7;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(4), .DIV_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .div        (div),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Line receiver: each frame must start at max(accept+1, previous end)
  // and hold every bit for div+1 clocks, div taken at the start edge.
  int   div_last = 0;
  bit   in_frame = 0;
  bit   missed = 0;
  int   start_e, per, k, bad, last_end, exp_s, b;
  logic [7:0] rx;
  logic expbit;
  exp_t cur;

  initial begin
    last_end = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 0;
        missed = 0;
        sbq.delete();
        last_end = 0;
      end else begin
        if (!in_frame) begin
          if (tx === 1'b0) begin
            if (sbq.size() == 0) begin
              chk("spurious_start", sbq.size(), 1);
            end else begin
              cur = sbq[0];
              exp_s = (cur.acc + 1 > last_end) ? cur.acc + 1 : last_end;
              chk("start_edge", cyc, exp_s);
            end
            in_frame = 1;
            start_e = cyc;
            per = div_last + 1;
            k = 0;
            bad = 0;
            rx = 8'h00;
          end else if (sbq.size() > 0 && !missed) begin
            exp_s = (sbq[0].acc + 1 > last_end) ? sbq[0].acc + 1 : last_end;
            if (cyc >= exp_s) begin
              chk("start_missing_tx", tx, 0);
              missed = 1;
            end
          end
        end
        if (in_frame) begin
          b = k / per;
          if (b == 0) expbit = 1'b0;
          else if (b == 9) expbit = 1'b1;
          else expbit = cur.data[b-1];
          if (tx !== expbit || busy !== 1'b1) bad++;
          if ((k % per) == (per / 2) && b >= 1 && b <= 8)
            rx[b-1] = tx;
          k++;
          if (k == 10 * per) begin
            in_frame = 0;
            missed = 0;
            last_end = start_e + 10 * per;
            if (sbq.size() > 0) begin
              chk("frame_bad_samples", bad, 0);
              chk("frame_byte", rx, cur.data);
              void'(sbq.pop_front());
            end
          end
        end
        if (wr_valid && wr_ready) begin
          exp_t e;
          e.data = wr_data;
          e.acc = cyc + 1;
          sbq.push_back(e);
        end
      end
      div_last = div;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] bt, output int waited);
    waited = 0;
    wr_valid = 1'b1;
    wr_data = bt;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      waited++;
      if (waited > 5000) begin
        chk("send_timeout", waited, 0);
        break;
      end
    end
    sync();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    wr_valid = 1'b0;
    while ((sbq.size() > 0 || in_frame || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, n < 20000, 1);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_count_end"}, fifo_count, 0);
    chk({name, "_tx_end"}, tx, 1);
    sync();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int tot;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    sync();
    reset = 1'b0;
    sync();

    div = 16'd7;
    send(8'h55, w);
    wr_valid = 1'b0;
    chk("t1_busy_during", busy, 1);
    drain("t1");

    div = 16'd3;
    tot = 0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), w);
      tot += w;
    end
    wr_valid = 1'b0;
    chk("t2_ready_waits", tot, 0);
    drain("t2");

    div = 16'd99;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), w);
    chk("t3_count_full", fifo_count, 4);
    chk("t3_ready_low", wr_ready, 0);
    send(8'h15, w);
    chk("t3_sixth_held", w > 0, 1);
    drain("t3");

    div = 16'd0;
    send(8'hA3, w);
    drain("t4");

    div = 16'd20;
    send(8'h41, w);
    wr_valid = 1'b0;
    repeat (40) sync();
    div = 16'd5;
    send(8'h3C, w);
    drain("tdiv");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) div = 16'($urandom_range(0, 6));
      send(8'($urandom), w);
      wr_valid = 1'b0;
      repeat ($urandom_range(0, 3)) sync();
    end
    drain("trand");

    div = 16'd3;
    send(8'hFF, w);
    send(8'h01, w);
    send(8'h02, w);
    wr_valid = 1'b0;
    repeat (15) sync();
    chk("t5_busy_before", busy, 1);
    chk("t5_count_before", fifo_count, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_tx_async", tx, 1);
    chk("t5_count_async", fifo_count, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_ready_async", wr_ready, 1);
    sync();
    sync();
    reset = 1'b0;
    repeat (100) sync();
    chk("t5_busy_after", busy, 0);
    chk("t5_tx_after", tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
